fifo_word_packer: RTL and testbench



---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_pack_outreg.sv | 35 +++
 rtl/fifo_word_packer.sv | 128 ++++++++++++
 tb/tb_fifo_word_packer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
// No logic, no latency; backpressure n/a.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PACK       = 4;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } pack_state_t;

    // Lane count -> per-lane keep mask (n low bits set); n >= 64 gives all ones.
    function automatic logic [63:0] keep_mask(input int unsigned n);
        return (64'd1 << n) - 64'd1;
    endfunction

endpackage

// File: rtl/fifo_pack_outreg.sv
// Valid/ready output holding register: loads a word, holds it until accepted.
// Latency: 1 cycle from load to valid.
// Backpressure: data/keep/valid stay stable while valid && !ready; caller loads only when !valid || ready.
module fifo_pack_outreg
    import fifo_pkg::*;
#(
    parameter int W = 32,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic [K-1:0] load_keep,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic [K-1:0] keep
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            keep  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            keep  <= load_keep;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_word_packer.sv
// Packs PACK FIFO entries into one wide word with keep mask; partial words flush on request or idle timeout.
// Latency: 2 cycles from the completing pop to m_valid. Optional FIFO_PACK_STATS_EN adds handoff counters.
// Backpressure: stalled output parks the accumulator in HOLD and stops popping, so the FIFO fills.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PACK       = DEF_PACK,
    parameter int TIMEOUT    = 16
`ifdef FIFO_PACK_STATS_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic                       rd_clk,
    input  logic                       rst_n,
    input  logic                       fifo_empty,
    input  logic [DATA_WIDTH-1:0]      fifo_dout,
    output logic                       fifo_rd_en,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_WIDTH*PACK-1:0] m_data,
    output logic [PACK-1:0]            m_keep,
`ifdef FIFO_PACK_STATS_EN
    output logic [CNT_W-1:0]           stat_words,
    output logic [CNT_W-1:0]           stat_flushes,
`endif
    input  logic                       flush
);

    localparam int LCW = $clog2(PACK + 1);
    localparam int LIW = $clog2(PACK);
    localparam int IW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    pack_state_t                          state;
    logic [LCW-1:0]                       lane_cnt;
    logic                                 inflight;
    logic                                 flush_pend;
    logic [IW-1:0]                        idle_cnt;
    logic [PACK-1:0][DATA_WIDTH-1:0]      acc;

    logic            full_word, timeout_hit, flush_req, complete, handoff;
    logic [LIW-1:0]  lane_idx;
    logic [PACK-1:0] keep_ld;

    always_comb begin
        full_word   = (lane_cnt == LCW'(PACK));
        timeout_hit = (TIMEOUT != 0) && (idle_cnt == IW'(TIMEOUT));
        flush_req   = flush || flush_pend || timeout_hit;
        // A flush waits for any in-flight pop so that entry lands in the word.
        complete    = full_word || (flush_req && (lane_cnt != '0) && !inflight);
        handoff     = complete && (!m_valid || m_ready);
        fifo_rd_en  = !fifo_empty && ((int'(lane_cnt) + int'(inflight)) < PACK) && (state != HOLD);
        lane_idx    = LIW'(lane_cnt);
        keep_ld     = PACK'(keep_mask(32'(lane_cnt)));
    end

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lane_cnt   <= '0;
            inflight   <= 1'b0;
            flush_pend <= 1'b0;
            idle_cnt   <= '0;
            acc        <= '0;
        end else begin
            inflight <= fifo_rd_en;

            // Handoff and capture never coincide: handoff requires !inflight or a full accumulator.
            if (handoff) begin
                lane_cnt <= '0;
                acc      <= '0;
            end else if (inflight) begin
                acc[lane_idx] <= fifo_dout;
                lane_cnt      <= lane_cnt + 1'b1;
            end

            if (handoff)
                flush_pend <= 1'b0;
            else if (flush && (lane_cnt != '0))
                flush_pend <= 1'b1;

            if (handoff || inflight)
                idle_cnt <= '0;
            else if ((lane_cnt != '0) && fifo_empty && !timeout_hit && (TIMEOUT != 0))
                idle_cnt <= idle_cnt + 1'b1;

            if (handoff)
                state <= IDLE;
            else if (complete)
                state <= HOLD;
            else if (inflight || (lane_cnt != '0))
                state <= FILL;
            else
                state <= IDLE;
        end
    end

    fifo_pack_outreg #(
        .W (DATA_WIDTH * PACK),
        .K (PACK)
    ) u_outreg (
        .clk       (rd_clk),
        .rst_n     (rst_n),
        .load      (handoff),
        .load_data (acc),
        .load_keep (keep_ld),
        .ready     (m_ready),
        .valid     (m_valid),
        .data      (m_data),
        .keep      (m_keep)
    );

`ifdef FIFO_PACK_STATS_EN
    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            stat_words   <= '0;
            stat_flushes <= '0;
        end else if (handoff) begin
            if (full_word && (stat_words != '1))
                stat_words <= stat_words + 1'b1;
            else if (!full_word && (stat_flushes != '1))
                stat_flushes <= stat_flushes + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: behavioural 16-deep FIFO in front, scoreboard of expected words behind.
module tb_fifo_word_packer;
    import fifo_pkg::*;

    logic        rd_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_dout = '0;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        flush = 1'b0;
`ifdef FIFO_PACK_STATS_EN
    logic [15:0] stat_words, stat_flushes;
`endif

    fifo_word_packer #(.DATA_WIDTH(8), .PACK(4), .TIMEOUT(16)) dut (
        .rd_clk       (rd_clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_dout    (fifo_dout),
        .fifo_rd_en   (fifo_rd_en),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_keep       (m_keep),
`ifdef FIFO_PACK_STATS_EN
        .stat_words   (stat_words),
        .stat_flushes (stat_flushes),
`endif
        .flush        (flush)
    );

    always #5 rd_clk = ~rd_clk;

    // Behavioural FIFO model
    logic [7:0]  fq[$];
    int          push_cnt = 0;
    int          pop_cnt  = 0;
    logic        fifo_full;
    assign fifo_empty = (push_cnt == pop_cnt);
    assign fifo_full  = ((push_cnt - pop_cnt) >= 16);

    always @(posedge rd_clk) begin
        if (fifo_rd_en && fq.size() > 0) begin
            fifo_dout <= fq.pop_front();
            pop_cnt   <= pop_cnt + 1;
        end
    end

    int          tests = 0;
    int          fails = 0;
    int          underflow = 0;
    logic [35:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: compare every handshake against the next expected word
    always @(negedge rd_clk) begin
        logic [35:0] e;
        if (fifo_rd_en && fifo_empty) underflow++;
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("words_outstanding", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("word_data", 64'(m_data), 64'(e[31:0]));
                check_eq("word_keep", 64'(m_keep), 64'(e[35:32]));
            end
        end
    end

    task automatic push(input logic [7:0] v);
        int t = 0;
        while (fifo_full && t < 2000) begin
            @(negedge rd_clk);
            t++;
        end
        fq.push_back(v);
        push_cnt++;
        @(negedge rd_clk);
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int t = 0;
        while ((exp_q.size() != 0 || m_valid) && t < budget) begin
            @(negedge rd_clk);
            t++;
        end
        check_eq(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [7:0] b;

        repeat (3) @(negedge rd_clk);
        check_eq("rst_m_valid", 64'(m_valid), 64'd0);
        check_eq("rst_m_data", 64'(m_data), 64'd0);
        check_eq("rst_m_keep", 64'(m_keep), 64'd0);
        check_eq("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check_eq("rst_lane_cnt", 64'(dut.lane_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge rd_clk);

        // Two full words
        m_ready = 1'b1;
        exp_q.push_back({4'hF, 32'h03020100});
        exp_q.push_back({4'hF, 32'h07060504});
        for (int i = 0; i < 8; i++) push(8'(i));
        wait_drain(100, "s1_drain");

        // Partial word flushed by idle timeout
        exp_q.push_back({4'h7, 32'h00121110});
        push(8'h10);
        push(8'h11);
        push(8'h12);
        t = 0;
        while (!m_valid && t < 100) begin
            @(negedge rd_clk);
            t++;
        end
        check_eq("s2_timeout_latency", 64'(t), 64'd18);
        wait_drain(50, "s2_drain");
`ifdef FIFO_PACK_STATS_EN
        check_eq("stat_words", 64'(stat_words), 64'd2);
        check_eq("stat_flushes", 64'(stat_flushes), 64'd1);
`endif

        // Output stall: 24 entries, back-pressure fills the FIFO
        m_ready = 1'b0;
        for (int w = 0; w < 6; w++)
            exp_q.push_back({4'hF, 8'(8'h43 + 4*w), 8'(8'h42 + 4*w), 8'(8'h41 + 4*w), 8'(8'h40 + 4*w)});
        for (int i = 0; i < 24; i++) push(8'(8'h40 + i));
        repeat (4) @(negedge rd_clk);
        check_eq("s3_fifo_full", 64'(fifo_full), 64'd1);
        check_eq("s3_m_valid", 64'(m_valid), 64'd1);
        check_eq("s3_state_hold", 64'(dut.state), 64'(HOLD));
        check_eq("s3_rd_en_low", 64'(fifo_rd_en), 64'd0);
        repeat (8) @(negedge rd_clk);
        check_eq("s3_hold_data", 64'(m_data), 64'h43424140);
        check_eq("s3_hold_keep", 64'(m_keep), 64'hF);
        check_eq("s3_fifo_level", 64'(push_cnt - pop_cnt), 64'd16);
        m_ready = 1'b1;
        wait_drain(400, "s3_drain");

        // Flush requested while the second entry is in flight
        exp_q.push_back({4'h3, 32'h00002120});
        push(8'h20);
        push(8'h21);
        t = 0;
        while (!(dut.inflight && dut.lane_cnt == 1) && t < 10) begin
            @(negedge rd_clk);
            t++;
        end
        check_eq("s4_flush_setup", 64'(t < 10), 64'd1);
        flush = 1'b1;
        @(negedge rd_clk);
        flush = 1'b0;
        wait_drain(50, "s4_drain");

        // Reset mid-operation with a held word and two filled lanes
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(8'h50 + i));
        repeat (4) @(negedge rd_clk);
        check_eq("s5_pre_valid", 64'(m_valid), 64'd1);
        check_eq("s5_pre_lanes", 64'(dut.lane_cnt), 64'd2);
        rst_n = 1'b0;
        @(negedge rd_clk);
        rst_n = 1'b1;
        check_eq("s5_post_valid", 64'(m_valid), 64'd0);
        check_eq("s5_post_lanes", 64'(dut.lane_cnt), 64'd0);
        check_eq("s5_post_keep", 64'(m_keep), 64'd0);
        m_ready = 1'b1;
        exp_q.push_back({4'hF, 32'h63626160});
        for (int i = 0; i < 4; i++) begin
            b = 8'(8'h60 + i);
            push(b);
        end
        wait_drain(100, "s5_drain");

        check_eq("no_rd_en_while_empty", 64'(underflow), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
